// File: rtl/ascon_finalization.sv
// Ascon-AEAD128 finalization stage. It injects the key into the state, runs one p12 call,
// and produces the tag. In decrypt mode it also compares the tag against an expected tag.
module ascon_finalization #(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         decrypt,
    input  logic [127:0] key,
    input  logic [127:0] exp_tag,
    input  logic [63:0]  x0,
    input  logic [63:0]  x1,
    input  logic [63:0]  x2,
    input  logic [63:0]  x3,
    input  logic [63:0]  x4,
    output logic [63:0]  x0_i_fin_p12,
    output logic [63:0]  x1_i_fin_p12,
    output logic [63:0]  x2_i_fin_p12,
    output logic [63:0]  x3_i_fin_p12,
    output logic [63:0]  x4_i_fin_p12,
    output logic         p12_start,
    input  logic [63:0]  x0_o_fin_p12,
    input  logic [63:0]  x1_o_fin_p12,
    input  logic [63:0]  x2_o_fin_p12,
    input  logic [63:0]  x3_o_fin_p12,
    input  logic [63:0]  x4_o_fin_p12,
    input  logic         p12_done,
    output logic [127:0] tag,
    output logic         tag_valid,
    input  logic         tag_ready,
    output logic         tag_match,
    output logic         err_timeout
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_OUT,
        S_ERR
    } state_t;

    state_t             state;
    logic [127:0]       key_q;
    logic [127:0]       exp_q;
    logic               dec_q;
    logic [CNT_W-1:0]   cnt;
    logic [127:0]       tag_next;
    logic               unused_p12;

    // The tag uses only the two low words of the permuted state.
    assign tag_next   = {x3_o_fin_p12 ^ key_q[127:64], x4_o_fin_p12 ^ key_q[63:0]};
    assign unused_p12 = ^{x0_o_fin_p12, x1_o_fin_p12, x2_o_fin_p12};

    // Sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            in_ready     <= 1'b1;
            key_q        <= '0;
            exp_q        <= '0;
            dec_q        <= 1'b0;
            cnt          <= '0;
            x0_i_fin_p12 <= '0;
            x1_i_fin_p12 <= '0;
            x2_i_fin_p12 <= '0;
            x3_i_fin_p12 <= '0;
            x4_i_fin_p12 <= '0;
            p12_start    <= 1'b0;
            tag          <= '0;
            tag_valid    <= 1'b0;
            tag_match    <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        key_q        <= key;
                        exp_q        <= exp_tag;
                        dec_q        <= decrypt;
                        x0_i_fin_p12 <= x0;
                        x1_i_fin_p12 <= x1;
                        x2_i_fin_p12 <= x2 ^ key[127:64];
                        x3_i_fin_p12 <= x3 ^ key[63:0];
                        x4_i_fin_p12 <= x4;
                        in_ready     <= 1'b0;
                        p12_start    <= 1'b1;
                        state        <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    p12_start <= 1'b0;
                    cnt       <= '0;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    // A done pulse wins over a timeout in the same cycle.
                    if (p12_done) begin
                        tag       <= tag_next;
                        tag_match <= dec_q & (tag_next == exp_q);
                        tag_valid <= 1'b1;
                        state     <= S_OUT;
                    end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        err_timeout <= 1'b1;
                        state       <= S_ERR;
                    end
                end
                S_OUT: begin
                    if (tag_ready) begin
                        tag       <= '0;
                        tag_match <= 1'b0;
                        tag_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                S_ERR: begin
                    err_timeout <= 1'b0;
                    in_ready    <= 1'b1;
                    state       <= S_IDLE;
                end
                default: begin
                    in_ready <= 1'b1;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_finalization.sv
// Directed bench for ascon_finalization. It drives table vectors through a scripted p12 responder,
// then runs hand-written sequences for backpressure, timeout and reset.
module tb_ascon_finalization;

    localparam int unsigned TO = 64;
    localparam logic [127:0] KEY1 = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] TAG1 = 128'hFFFEFDFCFBFAF9F808090A0B0C0D0E0F;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         decrypt;
    logic [127:0] key;
    logic [127:0] exp_tag;
    logic [63:0]  x0, x1, x2, x3, x4;
    logic [63:0]  x0_i, x1_i, x2_i, x3_i, x4_i;
    logic         p12_start;
    logic [63:0]  x0_o, x1_o, x2_o, x3_o, x4_o;
    logic         p12_done;
    logic [127:0] tag;
    logic         tag_valid;
    logic         tag_ready;
    logic         tag_match;
    logic         err_timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ascon_finalization #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .decrypt(decrypt), .key(key), .exp_tag(exp_tag),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3), .x4(x4),
        .x0_i_fin_p12(x0_i), .x1_i_fin_p12(x1_i), .x2_i_fin_p12(x2_i),
        .x3_i_fin_p12(x3_i), .x4_i_fin_p12(x4_i),
        .p12_start(p12_start),
        .x0_o_fin_p12(x0_o), .x1_o_fin_p12(x1_o), .x2_o_fin_p12(x2_o),
        .x3_o_fin_p12(x3_o), .x4_o_fin_p12(x4_o),
        .p12_done(p12_done),
        .tag(tag), .tag_valid(tag_valid), .tag_ready(tag_ready),
        .tag_match(tag_match), .err_timeout(err_timeout)
    );

    typedef struct {
        logic         dec;
        logic [127:0] k;
        logic [127:0] etag;
        logic [63:0]  sx0, sx2, sx3;
        logic [63:0]  px3, px4;
        logic [63:0]  want_x0i, want_x2i, want_x3i;
        logic [127:0] want_tag;
        logic         want_match;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are read 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_in(input logic dec, input logic [127:0] k, input logic [127:0] e,
                            input logic [63:0] a0, input logic [63:0] a2, input logic [63:0] a3);
        decrypt = dec; key = k; exp_tag = e;
        x0 = a0; x1 = '0; x2 = a2; x3 = a3; x4 = '0;
        in_valid = 1'b1;
    endtask

    // Accept, then LOAD, then WAIT for dly cycles, then the done pulse. Ends with the tag registered.
    task automatic run_to_out(input int dly, input logic [63:0] r3, input logic [63:0] r4);
        step();
        in_valid = 1'b0;
        step();
        for (int i = 0; i < dly; i++) step();
        x3_o = r3; x4_o = r4; p12_done = 1'b1;
        step();
        p12_done = 1'b0;
        x3_o = '0; x4_o = '0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; decrypt = 1'b0; key = '0; exp_tag = '0;
        x0 = '0; x1 = '0; x2 = '0; x3 = '0; x4 = '0;
        x0_o = 64'h1111; x1_o = 64'h2222; x2_o = 64'h3333; x3_o = '0; x4_o = '0;
        p12_done = 1'b0; tag_ready = 1'b1;

        vecs[0] = '{1'b0, KEY1, 128'h0, 64'h0, 64'h0, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h0,
                    64'h0, 64'h0001020304050607, 64'h08090A0B0C0D0E0F, TAG1, 1'b0};
        vecs[1] = '{1'b1, KEY1, TAG1, 64'h0, 64'h0, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h0,
                    64'h0, 64'h0001020304050607, 64'h08090A0B0C0D0E0F, TAG1, 1'b1};
        vecs[2] = '{1'b1, KEY1, 128'hFFFEFDFCFBFAF9F808090A0B0C0D0E0E, 64'h0, 64'h0, 64'h0,
                    64'hFFFFFFFFFFFFFFFF, 64'h0,
                    64'h0, 64'h0001020304050607, 64'h08090A0B0C0D0E0F, TAG1, 1'b0};
        vecs[3] = '{1'b1, KEY1, 128'h7FFEFDFCFBFAF9F808090A0B0C0D0E0F, 64'h0, 64'h0, 64'h0,
                    64'hFFFFFFFFFFFFFFFF, 64'h0,
                    64'h0, 64'h0001020304050607, 64'h08090A0B0C0D0E0F, TAG1, 1'b0};
        vecs[4] = '{1'b0, KEY1, TAG1, 64'h0, 64'h0, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h0,
                    64'h0, 64'h0001020304050607, 64'h08090A0B0C0D0E0F, TAG1, 1'b0};
        vecs[5] = '{1'b1, 128'h0, 128'h0123456789ABCDEFFEDCBA9876543210,
                    64'h1111111111111111, 64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555,
                    64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
                    64'h1111111111111111, 64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555,
                    128'h0123456789ABCDEFFEDCBA9876543210, 1'b1};

        step(); step();
        rst_n = 1'b1;
        step();
        chk("reset_in_ready", 128'(in_ready), 128'(1));
        chk("reset_tag_valid", 128'(tag_valid), 128'(0));
        chk("reset_tag", tag, 128'h0);
        chk("reset_p12_start", 128'(p12_start), 128'(0));
        chk("reset_err", 128'(err_timeout), 128'(0));
        chk("reset_x2i", 128'(x2_i), 128'(0));

        // T2: key injection and the p12_start pulse timing.
        drive_in(1'b0, KEY1, '0, '0, '0, '0);
        step();
        in_valid = 1'b0;
        chk("t2_p12_start_c1", 128'(p12_start), 128'(1));
        chk("t2_in_ready_c1", 128'(in_ready), 128'(0));
        chk("t2_x0i", 128'(x0_i), 128'(0));
        chk("t2_x1i", 128'(x1_i), 128'(0));
        chk("t2_x2i", 128'(x2_i), 128'(64'h0001020304050607));
        chk("t2_x3i", 128'(x3_i), 128'(64'h08090A0B0C0D0E0F));
        chk("t2_x4i", 128'(x4_i), 128'(0));
        step();
        chk("t2_p12_start_c2", 128'(p12_start), 128'(0));
        for (int i = 0; i < 11; i++) step();
        x3_o = 64'hFFFFFFFFFFFFFFFF; p12_done = 1'b1;
        chk("t2_tag_valid_pre", 128'(tag_valid), 128'(0));
        step();
        p12_done = 1'b0; x3_o = '0;
        chk("t2_tag_valid", 128'(tag_valid), 128'(1));
        chk("t2_tag", tag, TAG1);
        step();
        chk("t2_idle_in_ready", 128'(in_ready), 128'(1));

        // T1/T3: table vectors, covering encrypt, decrypt match, and bit-0/bit-127 mismatch.
        for (int v = 0; v < 6; v++) begin
            drive_in(vecs[v].dec, vecs[v].k, vecs[v].etag, vecs[v].sx0, vecs[v].sx2, vecs[v].sx3);
            tag_ready = 1'b1;
            run_to_out(11, vecs[v].px3, vecs[v].px4);
            chk($sformatf("v%0d_x0i", v), 128'(x0_i), 128'(vecs[v].want_x0i));
            chk($sformatf("v%0d_x2i", v), 128'(x2_i), 128'(vecs[v].want_x2i));
            chk($sformatf("v%0d_x3i", v), 128'(x3_i), 128'(vecs[v].want_x3i));
            chk($sformatf("v%0d_tag_valid", v), 128'(tag_valid), 128'(1));
            chk($sformatf("v%0d_tag", v), tag, vecs[v].want_tag);
            chk($sformatf("v%0d_match", v), 128'(tag_match), 128'(vecs[v].want_match));
            step();
            chk($sformatf("v%0d_after_valid", v), 128'(tag_valid), 128'(0));
            chk($sformatf("v%0d_after_tag", v), tag, 128'h0);
            chk($sformatf("v%0d_after_match", v), 128'(tag_match), 128'(0));
            chk($sformatf("v%0d_after_ready", v), 128'(in_ready), 128'(1));
        end

        // T4: backpressure, with in_valid ignored while busy.
        drive_in(1'b1, KEY1, TAG1, '0, '0, '0);
        tag_ready = 1'b0;
        step();
        drive_in(1'b0, '1, '0, '1, '1, '1);
        step();
        for (int i = 0; i < 3; i++) step();
        x3_o = 64'hFFFFFFFFFFFFFFFF; p12_done = 1'b1;
        step();
        p12_done = 1'b0; x3_o = '0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t4_valid_%0d", i), 128'(tag_valid), 128'(1));
            chk($sformatf("t4_tag_%0d", i), tag, TAG1);
            chk($sformatf("t4_match_%0d", i), 128'(tag_match), 128'(1));
            chk($sformatf("t4_in_ready_%0d", i), 128'(in_ready), 128'(0));
            step();
        end
        chk("t4_x2i_held", 128'(x2_i), 128'(64'h0001020304050607));
        in_valid = 1'b0;
        tag_ready = 1'b1;
        step();
        chk("t4_released", 128'(tag_valid), 128'(0));
        chk("t4_in_ready", 128'(in_ready), 128'(1));

        // T5: the timeout pulse lands exactly TO cycles after WAIT is entered.
        drive_in(1'b0, KEY1, '0, '0, '0, '0);
        step();
        in_valid = 1'b0;
        step();
        begin
            int early = 0;
            for (int i = 0; i < TO - 1; i++) begin
                step();
                if (err_timeout || tag_valid) early++;
            end
            chk("t5_no_early_err", 128'(early), 128'(0));
        end
        step();
        chk("t5_err_pulse", 128'(err_timeout), 128'(1));
        chk("t5_no_tag", 128'(tag_valid), 128'(0));
        chk("t5_busy", 128'(in_ready), 128'(0));
        step();
        chk("t5_err_cleared", 128'(err_timeout), 128'(0));
        chk("t5_in_ready", 128'(in_ready), 128'(1));
        x3_o = 64'hDEAD; p12_done = 1'b1;
        step();
        p12_done = 1'b0; x3_o = '0;
        chk("t5_late_done", 128'(tag_valid), 128'(0));
        chk("t5_late_tag", tag, 128'h0);

        // T6: reset in the middle of WAIT.
        drive_in(1'b0, KEY1, '0, '0, '0, '0);
        step();
        in_valid = 1'b0;
        step(); step(); step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t6_in_ready", 128'(in_ready), 128'(1));
        chk("t6_tag_valid", 128'(tag_valid), 128'(0));
        chk("t6_x3i_cleared", 128'(x3_i), 128'(0));
        x3_o = 64'hFFFFFFFFFFFFFFFF; p12_done = 1'b1;
        step();
        p12_done = 1'b0; x3_o = '0;
        chk("t6_no_tag", 128'(tag_valid), 128'(0));
        chk("t6_still_ready", 128'(in_ready), 128'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
